// File: rtl/io_output_reg_pkg.sv
// rtl/io_output_reg_pkg.sv - shared register codes, CTRL bit positions and blank display constants
package io_output_reg_pkg;

  localparam logic [5:0] ADDR_LED  = 6'b100000;
  localparam logic [5:0] ADDR_HEX  = 6'b100001;
  localparam logic [5:0] ADDR_CTRL = 6'b100010;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BLINK_BIT = 1;

  localparam logic [3:0] SEL_BLANK = 4'hF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex7seg_decoder.sv
// rtl/hex7seg_decoder.sv - 4-bit value to active-low gfedcba seven-segment code
module hex7seg_decoder (
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (value)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/io_output_reg.sv
// rtl/io_output_reg.sv - memory-mapped LED port and multiplexed 4-digit seven-segment display
module io_output_reg
  import io_output_reg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 256
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        wmem,
  output logic [31:0] io_read_data,
  output logic [7:0]  out_led,
  output logic        out_strobe,
  output logic [3:0]  hex_sel,
  output logic [6:0]  hex_seg
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [7:0]    led_reg;
  logic [31:0]   hex_reg;
  logic [1:0]    ctrl_reg;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          phase;

  logic [5:0]    code;
  logic          scan_wrap;
  logic          rot_wrap;
  logic          visible;
  logic [3:0]    nibble;
  logic [6:0]    seg_code;

  wire unused_addr_bits = &{1'b0, addr[31:8], addr[1:0]};

  assign code      = addr[7:2];
  assign scan_wrap = (scan_cnt == SCAN_LAST);
  assign rot_wrap  = scan_wrap && (idx == 2'd3);
  assign visible   = ctrl_reg[CTRL_EN_BIT] & (~ctrl_reg[CTRL_BLINK_BIT] | phase);
  assign nibble    = hex_reg[{idx, 2'b00} +: 4];
  assign out_led   = led_reg;

  hex7seg_decoder u_dec (
    .value (nibble),
    .seg   (seg_code)
  );

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      led_reg    <= '0;
      hex_reg    <= '0;
      ctrl_reg   <= '0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= wmem && (code == ADDR_LED);
      if (wmem) begin
        case (code)
          ADDR_LED:  led_reg  <= datain[7:0];
          ADDR_HEX:  hex_reg  <= datain;
          ADDR_CTRL: ctrl_reg <= datain[1:0];
          default: ;
        endcase
      end
    end
  end

  // Scan and blink timing free-run; CTRL only gates what reaches the pins.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      scan_cnt  <= '0;
      idx       <= 2'd0;
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap)
        idx <= idx + 2'd1;
      if (rot_wrap) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      hex_sel <= SEL_BLANK;
      hex_seg <= SEG_BLANK;
    end else if (visible) begin
      hex_sel <= ~(4'b0001 << idx);
      hex_seg <= seg_code;
    end else begin
      hex_sel <= SEL_BLANK;
      hex_seg <= SEG_BLANK;
    end
  end

  always_comb begin
    io_read_data = '0;
    case (code)
      ADDR_LED:  io_read_data = {24'd0, led_reg};
      ADDR_HEX:  io_read_data = hex_reg;
      ADDR_CTRL: io_read_data = {30'd0, ctrl_reg};
      default:   io_read_data = '0;
    endcase
  end

endmodule
